pipeline_mem_responder: RTL and testbench
=========================================

# pipeline_mem_responder

Synthesizable memory responder for the CPU's pipelined imem/dmem port: addr, rmask, wmask, wdata, rdata, resp. It accepts one request per cycle, commits byte-masked writes to an internal word array, and returns every request's response after a fixed LATENCY through a shift pipeline. It sits on the memory side of the CPU, replacing the behavioural memory model in FPGA and synthesis builds. One instance serves each channel: instruction or data.

## Interface
- DEPTH_LOG2, 10: array holds 2^DEPTH_LOG2 32-bit words; byte address space is 4·2^DEPTH_LOG2.
- LATENCY, 2: cycles from request acceptance to resp; legal range 1..8.
- clk  in  1: sole clock; all state on posedge.
- rst_n  in  1: asynchronous, active-low reset.
- addr  in  32: byte address; must be word-aligned.
- rmask  in  4: read byte enables; nonzero marks a read request.
- wmask  in  4: write byte enables; nonzero marks a write request.
- wdata  in  32: write data, lane i = wdata[8i+7:8i].
- rdata  out  32: read data, valid while resp=1 for a read.
- resp  out  1: one-cycle pulse per completed request, in issue order.
- error  out  1: sticky protocol-error flag.

## Operation
- Request: any posedge where rmask!=0 or wmask!=0. Accepted unconditionally, with no backpressure; zero masks mean idle.
- Word index: idx = addr[DEPTH_LOG2+1:2].
- Fault conditions:
  - addr[1:0]!=0;
  - addr >= 4·2^DEPTH_LOG2;
  - rmask!=0 and wmask!=0 together.
  - A faulting request still gets resp, so the CPU never hangs. Its write is suppressed and its read data is 32'h0. error sets and holds until reset.
- Write: at the accepting edge, bytes with wmask[i]=1 update array[idx]; other lanes are unchanged.
- Read: array[idx] is sampled at the accepting edge and carried down the pipeline.
  - The full word is returned; the CPU applies rmask itself.
  - A read accepted in the cycle after a write to the same word returns the written data. No hazard logic is needed because requests serialize.
- Pipeline: LATENCY stages, each holding {valid, is_read, data}. Stage 0 loads on acceptance; stage k loads from stage k-1 every cycle. resp = valid of the last stage.
- rdata: loads the last-stage data when the last stage is a valid read. It holds its previous value otherwise, including on write responses.
- Array contents are not reset.

## Timing
- Reset values: resp=0, rdata=32'h0, error=0, all stage valids 0. Asynchronous assert; deassert takes effect from the next posedge.
- Latency: request sampled at edge N, resp=1 during the cycle following edge N+LATENCY-1.
  - LATENCY=1 gives resp in the cycle right after the request cycle.
- Throughput: one request per cycle. A continuous request stream gives continuous resp=1 after the fill latency.
- Ordering: responses are strictly in issue order, and the count of responses equals the count of accepted requests.
- Reset mid-operation: in-flight responses are discarded with no resp. Writes already committed at their accepting edge remain in the array.
- A request in the same cycle as a resp is legal; the pipeline shifts and loads simultaneously.
- Address wrap-around: not performed; out-of-range addresses fault.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random masks on the inputs -> resp, error and rdata all 0. After release, with idle inputs, resp stays 0.
- Write/read: write 32'hDEADBEEF to 0x40 with wmask=4'hF, then read 0x40 with rmask=4'hF the next cycle -> two resp pulses, with rdata=32'hDEADBEEF on the second. For LATENCY=2, that pulse arrives 2 cycles after the read request.
- Byte mask: with 0x40=32'hDEADBEEF, write wdata=32'h11223344 with wmask=4'b0101, then read -> rdata=32'hDE22BE44.
- Back-to-back: 16 consecutive writes to 0x00..0x3C (data = addr), then 16 consecutive reads -> resp high for 32 consecutive cycles. Reads return 0x00..0x3C in order.
- Faults: read addr=0x41; then write at 4·2^DEPTH_LOG2; then rmask=wmask=4'hF -> each gets resp, the read returns rdata=0, no array word changes, and error=1 stays set.
- Reset mid-flight: issue a write to 0x80 then a read, and assert rst_n before either resp -> no resp appears. After release, a read of 0x80 returns the new write data.

Source files
------------

// File: rtl/pipeline_mem_responder_if.sv
// Pipelined memory request/response bus between a CPU channel and its memory responder.
interface pipeline_mem_responder_if;
  logic [31:0] addr;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp;
  logic        error;

  modport master (
    output addr, rmask, wmask, wdata,
    input  rdata, resp, error
  );

  modport slave (
    input  addr, rmask, wmask, wdata,
    output rdata, resp, error
  );
endinterface

// File: rtl/pipeline_mem_responder.sv
// Fixed-latency memory responder: one request per cycle, byte-masked writes committed at
// acceptance, every response returned in order after LATENCY cycles through a shift pipeline.
module pipeline_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  pipeline_mem_responder_if.slave bus
);
  localparam int unsigned Words = 1 << DEPTH_LOG2;

  logic [31:0]           mem [Words];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  rd_req;
  logic                  wr_req;
  logic                  req;
  logic                  fault;

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] is_read_q;
  logic [31:0]        data_q [LATENCY];
  logic [LATENCY-1:0] valid_in;
  logic [LATENCY-1:0] is_read_in;
  logic [31:0]        data_in [LATENCY];
  logic               error_q;

  assign rd_req = |bus.rmask;
  assign wr_req = |bus.wmask;
  assign req    = rd_req | wr_req;
  assign idx    = bus.addr[DEPTH_LOG2+1:2];
  // Any set bit above the array's byte range means out of range; no wrap-around.
  assign fault  = (bus.addr[1:0] != 2'b00) | (|bus.addr[31:DEPTH_LOG2+2]) | (rd_req & wr_req);

  always_ff @(posedge clk) begin
    if (wr_req && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wmask[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    valid_in      = '0;
    is_read_in    = '0;
    valid_in[0]   = req;
    is_read_in[0] = rd_req;
    // Sampled before this edge's write lands; faulting reads return zero.
    data_in[0]    = (rd_req && !fault) ? mem[idx] : 32'h0;
    for (int k = 1; k < int'(LATENCY); k++) begin
      valid_in[k]   = valid_q[k-1];
      is_read_in[k] = is_read_q[k-1];
      data_in[k]    = data_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      is_read_q <= '0;
      error_q   <= 1'b0;
      for (int k = 0; k < int'(LATENCY); k++) data_q[k] <= 32'h0;
    end else begin
      valid_q   <= valid_in;
      is_read_q <= is_read_in;
      for (int k = 0; k < int'(LATENCY) - 1; k++) data_q[k] <= data_in[k];
      // Last stage doubles as the rdata holding register.
      if (valid_in[LATENCY-1] && is_read_in[LATENCY-1]) begin
        data_q[LATENCY-1] <= data_in[LATENCY-1];
      end
      if (req && fault) error_q <= 1'b1;
    end
  end

  assign bus.resp  = valid_q[LATENCY-1];
  assign bus.rdata = data_q[LATENCY-1];
  assign bus.error = error_q;
endmodule

// File: tb/tb_pipeline_mem_responder.sv
// Directed bench for pipeline_mem_responder: vector table plus back-to-back and reset sequences.
module tb_pipeline_mem_responder;
  localparam int unsigned DEPTH_LOG2 = 10;
  localparam int unsigned LATENCY    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipeline_mem_responder_if bus ();

  pipeline_mem_responder #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .LATENCY   (LATENCY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        exp_resp;
    logic [31:0] exp_rdata;
    logic        exp_error;
  } vec_t;

  vec_t vecs [13];

  task automatic drive(input logic [31:0] addr, input logic [3:0] rmask,
                       input logic [3:0] wmask, input logic [31:0] wdata);
    @(negedge clk);
    bus.addr  = addr;
    bus.rmask = rmask;
    bus.wmask = wmask;
    bus.wdata = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic resp, input logic [31:0] rdata,
                            input logic error);
    check({name, ".resp"}, {31'h0, bus.resp}, {31'h0, resp});
    check({name, ".rdata"}, bus.rdata, rdata);
    check({name, ".error"}, {31'h0, bus.error}, {31'h0, error});
  endtask

  initial begin
    // Outputs are those visible after the edge that samples the row's inputs.
    vecs[0]  = '{32'h40,   4'h0, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{32'h40,   4'hF, 4'h0, 32'h0,        1'b1, 32'h0,        1'b0};
    vecs[2]  = '{32'h40,   4'h0, 4'h5, 32'h11223344, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{32'h40,   4'hF, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{32'h0,    4'h0, 4'hF, 32'hA5A5A5A5, 1'b1, 32'hDE22BE44, 1'b0};
    vecs[5]  = '{32'h0,    4'h0, 4'h0, 32'h0,        1'b1, 32'hDE22BE44, 1'b0};
    vecs[6]  = '{32'h41,   4'hF, 4'h0, 32'h0,        1'b0, 32'hDE22BE44, 1'b1};
    vecs[7]  = '{32'h1000, 4'h0, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
    vecs[8]  = '{32'h40,   4'hF, 4'hF, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[9]  = '{32'h40,   4'hF, 4'h0, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[10] = '{32'h0,    4'hF, 4'h0, 32'h0,        1'b1, 32'hDE22BE44, 1'b1};
    vecs[11] = '{32'h0,    4'h0, 4'h0, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b1};
    vecs[12] = '{32'h0,    4'h0, 4'h0, 32'h0,        1'b0, 32'hA5A5A5A5, 1'b1};

    bus.addr  = 32'h0;
    bus.rmask = 4'h0;
    bus.wmask = 4'h0;
    bus.wdata = 32'h0;

    // Reset held with live request masks on the inputs.
    for (int i = 0; i < 3; i++) begin
      drive(32'h40, 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), $urandom);
      tick();
      check_outs($sformatf("reset%0d", i), 1'b0, 32'h0, 1'b0);
    end
    drive(32'h0, 4'h0, 4'h0, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_outs($sformatf("idle%0d", i), 1'b0, 32'h0, 1'b0);
    end

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].addr, vecs[i].rmask, vecs[i].wmask, vecs[i].wdata);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_resp, vecs[i].exp_rdata, vecs[i].exp_error);
    end

    // 16 writes then 16 reads back-to-back: resp must stay high for 32 cycles.
    for (int i = 0; i < 32; i++) begin
      if (i < 16) drive(32'(i * 4), 4'h0, 4'hF, 32'(i * 4));
      else        drive(32'((i - 16) * 4), 4'hF, 4'h0, 32'h0);
      tick();
      check($sformatf("b2b%0d.resp", i), {31'h0, bus.resp}, (i == 0) ? 32'h0 : 32'h1);
      if (i >= 17) check($sformatf("b2b%0d.rdata", i), bus.rdata, 32'((i - 17) * 4));
    end
    drive(32'h0, 4'h0, 4'h0, 32'h0);
    tick();
    check("b2b_last.resp", {31'h0, bus.resp}, 32'h1);
    check("b2b_last.rdata", bus.rdata, 32'h3C);
    tick();
    check("b2b_drain.resp", {31'h0, bus.resp}, 32'h0);

    // Reset while a write and a following read are in flight.
    drive(32'h80, 4'h0, 4'hF, 32'h12345678);
    tick();
    bus.addr  = 32'h80;
    bus.rmask = 4'hF;
    bus.wmask = 4'h0;
    rst_n     = 1'b0;
    #1;
    check_outs("midrst_async", 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_outs($sformatf("midrst%0d", i), 1'b0, 32'h0, 1'b0);
    end
    drive(32'h0, 4'h0, 4'h0, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("postrst%0d", i), 1'b0, 32'h0, 1'b0);
    end
    drive(32'h80, 4'hF, 4'h0, 32'h0);
    tick();
    check_outs("rd80_a", 1'b0, 32'h0, 1'b0);
    drive(32'h0, 4'h0, 4'h0, 32'h0);
    tick();
    check_outs("rd80_b", 1'b1, 32'h12345678, 1'b0);
    tick();
    check_outs("rd80_c", 1'b0, 32'h12345678, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
